// File: rtl/instruction_fetch.sv
// Three-byte instruction fetch unit: owns the PC, reads opcode/operand bytes from
// program memory and holds the assembled instruction until the IR stage acknowledges it.
// Optional per-byte memory timeout with sticky error flag: define FETCH_TIMEOUT_EN.
module instruction_fetch #(
    parameter int                 ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    input  logic              mem_ack,
    output logic [7:0]        opcode,
    output logic [7:0]        operando1,
    output logic [7:0]        operando2,
    output logic              IR_load,
    input  logic              ir_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_err
);

    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, HOLD} state_t;

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("instruction_fetch: TIMEOUT must be at least 1");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [7:0]        op1_q, op1_d;
    logic [7:0]        op2_q, op2_d;
    logic              fetch_block;

`ifdef FETCH_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    assign fetch_block = err_q;
    assign fetch_err   = err_q;
`else
    assign fetch_block = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement leaves one unassigned and infers a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        opcode_d = opcode_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
`ifdef FETCH_TIMEOUT_EN
        tmo_d    = tmo_q;
        err_d    = err_q;
`endif

        unique case (state_q)
            IDLE: if (fetch_en && !fetch_block) state_d = RD0;
            RD0: if (mem_ack) begin
                opcode_d = mem_data;
                pc_d     = pc_q + 1'b1;
                state_d  = RD1;
            end
            RD1: if (mem_ack) begin
                op1_d   = mem_data;
                pc_d    = pc_q + 1'b1;
                state_d = RD2;
            end
            RD2: if (mem_ack) begin
                op2_d   = mem_data;
                pc_d    = pc_q + 1'b1;
                state_d = HOLD;
            end
            HOLD: if (ir_ack) state_d = fetch_en ? RD0 : IDLE;
            default: state_d = IDLE;
        endcase

`ifdef FETCH_TIMEOUT_EN
        // The counter restarts for every byte: an ack clears it before the next RDn.
        if (state_q inside {RD0, RD1, RD2}) begin
            if (mem_ack) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                err_d   = 1'b1;
                state_d = IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif

        // A redirect overrides everything, including a capture or ack in this cycle.
        if (jump_en) begin
            state_d  = IDLE;
            pc_d     = jump_addr;
            opcode_d = opcode_q;
            op1_d    = op1_q;
            op2_d    = op2_q;
`ifdef FETCH_TIMEOUT_EN
            tmo_d    = '0;
            err_d    = err_q;
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            opcode_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            opcode_q <= opcode_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
`endif

    assign mem_rd    = (state_q == RD0) || (state_q == RD1) || (state_q == RD2);
    assign IR_load   = (state_q == HOLD);
    assign mem_addr  = pc_q;
    assign pc        = pc_q;
    assign opcode    = opcode_q;
    assign operando1 = op1_q;
    assign operando2 = op2_q;

endmodule
